// File: rtl/mem_stage_hs_pkg.sv
`default_nettype none
// ============================================================================
// mem_stage_pkg : shared types and MMIO defaults for the MEM stage
// Revision 1.0
// ============================================================================
package mem_stage_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam logic [31:0] UART_ADDR_DEF = 32'hf6fff070;
    localparam logic [31:0] HC_ADDR_DEF   = 32'hffffff00;

    typedef enum logic [1:0] {
        MW_BYTE = 2'b00,
        MW_HALF = 2'b01,
        MW_WORD = 2'b10
    } access_width_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] irreg_pc;
        logic [XLEN_DEF-1:0] alu_result;
        logic [XLEN_DEF-1:0] w_data;
        logic                w_enable;
        logic [4:0]          rd_addr;
        logic                is_store;
        logic                is_load;
        logic                is_load_unsigned;
        logic [1:0]          width;
    } cap_t;

    // Width 2'b11 is illegal and behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] a);
        case (width)
            MW_BYTE: return 1'b0;
            MW_HALF: return a[0];
            default: return (a != 2'b00);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_hs_if.sv
`default_nettype none
// ============================================================================
// mem_stage_hs_if : request/response data-memory port
// Revision 1.0
// ============================================================================
interface mem_stage_hs_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [XLEN-1:0] req_addr;
    logic [3:0]      req_be;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_hs_lsu_align.sv
`default_nettype none
// ============================================================================
// lsu_align : byte-lane enables, store shift and load extract/extend
// Revision 1.0
// ============================================================================
module lsu_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      addr_lo,
    input  logic [1:0]      width,
    input  logic            is_unsigned,
    input  logic [XLEN-1:0] st_data,
    input  logic [XLEN-1:0] ld_raw,
    output logic [3:0]      be,
    output logic [XLEN-1:0] st_wdata,
    output logic [XLEN-1:0] ld_data
);

    logic [XLEN-1:0] ld_shift;

    always_comb begin
        ld_shift = ld_raw >> {addr_lo, 3'b000};
        st_wdata = st_data << {addr_lo, 3'b000};
        be       = 4'b1111;
        ld_data  = ld_shift;
        case (width)
            MW_BYTE: begin
                be      = 4'b0001 << addr_lo;
                ld_data = {{(XLEN-8){~is_unsigned & ld_shift[7]}}, ld_shift[7:0]};
            end
            MW_HALF: begin
                be      = 4'b0011 << addr_lo;
                ld_data = {{(XLEN-16){~is_unsigned & ld_shift[15]}}, ld_shift[15:0]};
            end
            default: begin
                be      = 4'b1111;
                ld_data = ld_shift;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage_hs.sv
`default_nettype none
// ============================================================================
// mem_stage_hs : RV32I MEM stage with valid/ready handshakes, dmem port, MMIO
// Revision 1.0
// ============================================================================
module mem_stage_hs
    import mem_stage_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] UART_ADDR = UART_ADDR_DEF,
    parameter logic [XLEN-1:0] HC_ADDR   = HC_ADDR_DEF
) (
    input  wire logic            clk,
    input  wire logic            rstd,
    input  wire logic            in_valid,
    output logic                 in_ready,
    input  wire logic [XLEN-1:0] pc,
    input  wire logic [XLEN-1:0] irreg_pc,
    input  wire logic            w_enable,
    input  wire logic [4:0]      rd_addr,
    input  wire logic            is_store,
    input  wire logic            is_load,
    input  wire logic            is_load_unsigned,
    input  wire logic [XLEN-1:0] alu_result,
    input  wire logic [1:0]      mem_access_width,
    input  wire logic [XLEN-1:0] w_data,
    mem_stage_hs_if.master       dmem,
    output logic                 out_valid,
    input  wire logic            out_ready,
    output logic [XLEN-1:0]      MW_pc,
    output logic [XLEN-1:0]      MW_irreg_pc,
    output logic [XLEN-1:0]      MW_r_data,
    output logic [XLEN-1:0]      MW_alu_result,
    output logic                 MW_is_load,
    output logic                 MW_w_enable,
    output logic                 MW_misalign,
    output logic [4:0]           MW_rd_addr,
    output logic [7:0]           uart,
    output logic                 uart_we,
    output logic                 hc_access
);

    state_e          state_q, state_d;
    cap_t            cap_q, cap_d, in_cap, done_src;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] mw_pc_q, mw_pc_d, mw_irreg_pc_q, mw_irreg_pc_d;
    logic [XLEN-1:0] mw_r_data_q, mw_r_data_d, mw_alu_q, mw_alu_d;
    logic            mw_is_load_q, mw_is_load_d, mw_w_enable_q, mw_w_enable_d;
    logic            mw_misalign_q, mw_misalign_d;
    logic [4:0]      mw_rd_addr_q, mw_rd_addr_d;
    logic [7:0]      uart_q, uart_d;
    logic            uart_we_q, uart_we_d;

    logic            mw_free, accept, complete, done_mis, misalign, uart_hit, hc_hit;
    logic [XLEN-1:0] done_rdata, ld_data;

    lsu_align #(.XLEN(XLEN)) u_lsu_align (
        .addr_lo     (cap_q.alu_result[1:0]),
        .width       (cap_q.width),
        .is_unsigned (cap_q.is_load_unsigned),
        .st_data     (cap_q.w_data),
        .ld_raw      (dmem.resp_rdata),
        .be          (dmem.req_be),
        .st_wdata    (dmem.req_wdata),
        .ld_data     (ld_data)
    );

    // The request is driven purely from the capture register, so it stays stable until accepted.
    assign dmem.req_valid = (state_q == REQ);
    assign dmem.req_we    = cap_q.is_store;
    assign dmem.req_addr  = {cap_q.alu_result[XLEN-1:2], 2'b00};

    always_comb begin
        in_cap = '{pc: pc, irreg_pc: irreg_pc, alu_result: alu_result, w_data: w_data,
                   w_enable: w_enable, rd_addr: rd_addr, is_store: is_store, is_load: is_load,
                   is_load_unsigned: is_load_unsigned, width: mem_access_width};
        mw_free   = !out_valid_q || out_ready;
        in_ready  = (state_q == IDLE) && mw_free;
        accept    = in_valid && in_ready;
        hc_access = in_valid && (alu_result == HC_ADDR);
        misalign  = (is_load || is_store) && is_misaligned(mem_access_width, alu_result[1:0]);
        uart_hit  = is_store && (alu_result == UART_ADDR);
        hc_hit    = (alu_result == HC_ADDR);

        state_d    = state_q;
        cap_d      = cap_q;
        uart_d     = uart_q;
        uart_we_d  = 1'b0;
        complete   = 1'b0;
        done_src   = in_cap;
        done_mis   = 1'b0;
        done_rdata = '0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (misalign) begin
                        complete = 1'b1;
                        done_mis = 1'b1;
                    end else if (uart_hit) begin
                        complete  = 1'b1;
                        uart_d    = w_data[7:0];
                        uart_we_d = 1'b1;
                    end else if (hc_hit || !(is_load || is_store)) begin
                        complete = 1'b1;
                    end else begin
                        cap_d   = in_cap;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem.req_ready) begin
                    if (cap_q.is_load) begin
                        state_d = RESP;
                    end else if (mw_free) begin
                        complete = 1'b1;
                        done_src = cap_q;
                        state_d  = IDLE;
                    end
                end
            end
            RESP: begin
                if (dmem.resp_valid && mw_free) begin
                    complete   = 1'b1;
                    done_src   = cap_q;
                    done_rdata = ld_data;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        out_valid_d   = out_valid_q;
        mw_pc_d       = mw_pc_q;
        mw_irreg_pc_d = mw_irreg_pc_q;
        mw_r_data_d   = mw_r_data_q;
        mw_alu_d      = mw_alu_q;
        mw_is_load_d  = mw_is_load_q;
        mw_w_enable_d = mw_w_enable_q;
        mw_misalign_d = mw_misalign_q;
        mw_rd_addr_d  = mw_rd_addr_q;
        if (complete) begin
            out_valid_d   = 1'b1;
            mw_pc_d       = done_src.pc;
            mw_irreg_pc_d = done_src.irreg_pc;
            mw_r_data_d   = done_rdata;
            mw_alu_d      = done_src.alu_result;
            mw_is_load_d  = done_src.is_load;
            mw_w_enable_d = done_src.w_enable && !done_mis;
            mw_misalign_d = done_mis;
            mw_rd_addr_d  = done_src.rd_addr;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstd) begin
        if (!rstd) begin
            state_q       <= IDLE;
            cap_q         <= '0;
            out_valid_q   <= 1'b0;
            mw_pc_q       <= '0;
            mw_irreg_pc_q <= '0;
            mw_r_data_q   <= '0;
            mw_alu_q      <= '0;
            mw_is_load_q  <= 1'b0;
            mw_w_enable_q <= 1'b0;
            mw_misalign_q <= 1'b0;
            mw_rd_addr_q  <= '0;
            uart_q        <= '0;
            uart_we_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cap_q         <= cap_d;
            out_valid_q   <= out_valid_d;
            mw_pc_q       <= mw_pc_d;
            mw_irreg_pc_q <= mw_irreg_pc_d;
            mw_r_data_q   <= mw_r_data_d;
            mw_alu_q      <= mw_alu_d;
            mw_is_load_q  <= mw_is_load_d;
            mw_w_enable_q <= mw_w_enable_d;
            mw_misalign_q <= mw_misalign_d;
            mw_rd_addr_q  <= mw_rd_addr_d;
            uart_q        <= uart_d;
            uart_we_q     <= uart_we_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign MW_pc         = mw_pc_q;
    assign MW_irreg_pc   = mw_irreg_pc_q;
    assign MW_r_data     = mw_r_data_q;
    assign MW_alu_result = mw_alu_q;
    assign MW_is_load    = mw_is_load_q;
    assign MW_w_enable   = mw_w_enable_q;
    assign MW_misalign   = mw_misalign_q;
    assign MW_rd_addr    = mw_rd_addr_q;
    assign uart          = uart_q;
    assign uart_we       = uart_we_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_hs.sv
`default_nettype none
// ============================================================================
// tb_mem_stage_hs : directed table-driven bench for mem_stage_hs
// Revision 1.0
// ============================================================================
module tb_mem_stage_hs;

    logic        clk = 1'b0;
    logic        rstd;
    logic        in_valid, in_ready, w_enable, is_store, is_load, is_load_unsigned;
    logic [31:0] pc, irreg_pc, alu_result, w_data;
    logic [4:0]  rd_addr;
    logic [1:0]  mem_access_width;
    logic        out_valid, out_ready;
    logic [31:0] MW_pc, MW_irreg_pc, MW_r_data, MW_alu_result;
    logic        MW_is_load, MW_w_enable, MW_misalign;
    logic [4:0]  MW_rd_addr;
    logic [7:0]  uart;
    logic        uart_we, hc_access;

    int checks = 0;
    int errors = 0;

    mem_stage_hs_if #(.XLEN(32)) dmem ();

    mem_stage_hs dut (
        .clk(clk), .rstd(rstd), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .irreg_pc(irreg_pc), .w_enable(w_enable), .rd_addr(rd_addr),
        .is_store(is_store), .is_load(is_load), .is_load_unsigned(is_load_unsigned),
        .alu_result(alu_result), .mem_access_width(mem_access_width), .w_data(w_data),
        .dmem(dmem), .out_valid(out_valid), .out_ready(out_ready),
        .MW_pc(MW_pc), .MW_irreg_pc(MW_irreg_pc), .MW_r_data(MW_r_data),
        .MW_alu_result(MW_alu_result), .MW_is_load(MW_is_load), .MW_w_enable(MW_w_enable),
        .MW_misalign(MW_misalign), .MW_rd_addr(MW_rd_addr), .uart(uart), .uart_we(uart_we),
        .hc_access(hc_access)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       nm;
        logic        ld;
        logic        st;
        logic [1:0]  wd;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic        exp_hc;
        logic        exp_mis;
        logic        exp_wen;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        in_valid = 0; is_load = 0; is_store = 0; is_load_unsigned = 0;
    endtask

    task automatic do_store(input string nm, input logic [31:0] addr, input logic [1:0] wd,
                            input logic [31:0] data, input int waits,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        in_valid = 1; is_store = 1; is_load = 0; alu_result = addr; mem_access_width = wd;
        w_data = data; w_enable = 0; rd_addr = 5'd0; pc = 32'h300;
        #1 chk({nm, "/in_ready"}, in_ready, 1);
        step();
        clear_inputs();
        for (int k = 0; k <= waits; k++) begin
            chk({nm, "/req_valid"}, dmem.req_valid, 1);
            chk({nm, "/we"}, dmem.req_we, 1);
            chk({nm, "/addr"}, dmem.req_addr, {addr[31:2], 2'b00});
            chk({nm, "/be"}, dmem.req_be, exp_be);
            chk({nm, "/wdata"}, dmem.req_wdata, exp_wdata);
            chk({nm, "/out_valid_early"}, out_valid, 0);
            if (k == waits) dmem.req_ready = 1;
            step();
        end
        dmem.req_ready = 0;
        #1;
        chk({nm, "/out_valid"}, out_valid, 1);
        chk({nm, "/req_done"}, dmem.req_valid, 0);
        chk({nm, "/MW_alu"}, MW_alu_result, addr);
        chk({nm, "/MW_is_load"}, MW_is_load, 0);
    endtask

    task automatic do_load(input string nm, input logic [31:0] addr, input logic [1:0] wd,
                           input logic uns, input logic [31:0] raw, input int delay,
                           input logic [31:0] exp_data, input logic [3:0] exp_be);
        in_valid = 1; is_load = 1; is_store = 0; is_load_unsigned = uns; alu_result = addr;
        mem_access_width = wd; w_enable = 1; rd_addr = 5'd9; pc = 32'h400;
        #1 chk({nm, "/in_ready"}, in_ready, 1);
        step();
        clear_inputs();
        // response arriving while still in REQ must be ignored
        dmem.resp_valid = 1; dmem.resp_rdata = 32'hFFFF_FFFF;
        #1;
        chk({nm, "/req_valid"}, dmem.req_valid, 1);
        chk({nm, "/we"}, dmem.req_we, 0);
        chk({nm, "/be"}, dmem.req_be, exp_be);
        chk({nm, "/addr"}, dmem.req_addr, {addr[31:2], 2'b00});
        step();
        dmem.resp_valid = 0;
        chk({nm, "/req_held"}, dmem.req_valid, 1);
        chk({nm, "/addr_held"}, dmem.req_addr, {addr[31:2], 2'b00});
        dmem.req_ready = 1;
        step();
        dmem.req_ready = 0;
        #1;
        chk({nm, "/req_done"}, dmem.req_valid, 0);
        chk({nm, "/in_ready_resp"}, in_ready, 0);
        for (int k = 0; k < delay; k++) begin
            step();
            chk({nm, "/in_ready_wait"}, in_ready, 0);
            chk({nm, "/out_valid_wait"}, out_valid, 0);
        end
        dmem.resp_valid = 1; dmem.resp_rdata = raw;
        step();
        dmem.resp_valid = 0; dmem.resp_rdata = 32'h0;
        chk({nm, "/out_valid"}, out_valid, 1);
        chk({nm, "/MW_r_data"}, MW_r_data, exp_data);
        chk({nm, "/MW_is_load"}, MW_is_load, 1);
        chk({nm, "/MW_alu"}, MW_alu_result, addr);
        chk({nm, "/MW_wen"}, MW_w_enable, 1);
        chk({nm, "/MW_rd"}, MW_rd_addr, 5'd9);
    endtask

    initial begin
        vecs[0] = '{"alu",       1'b0, 1'b0, 2'b10, 32'h0000_1234, 5'd5,  1'b0, 1'b0, 1'b1};
        vecs[1] = '{"mis_ldw",   1'b1, 1'b0, 2'b10, 32'h0000_0101, 5'd7,  1'b0, 1'b1, 1'b0};
        vecs[2] = '{"mis_sth",   1'b0, 1'b1, 2'b01, 32'h0000_0203, 5'd8,  1'b0, 1'b1, 1'b0};
        vecs[3] = '{"hc_ld",     1'b1, 1'b0, 2'b10, 32'hFFFF_FF00, 5'd10, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{"mis_ldh",   1'b1, 1'b0, 2'b01, 32'h0000_0011, 5'd11, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{"alu_hc",    1'b0, 1'b0, 2'b00, 32'hFFFF_FF00, 5'd12, 1'b1, 1'b0, 1'b1};

        rstd = 0; out_ready = 1; clear_inputs();
        pc = 0; irreg_pc = 0; w_enable = 0; rd_addr = 0; alu_result = 0;
        mem_access_width = 0; w_data = 0;
        dmem.req_ready = 0; dmem.resp_valid = 0; dmem.resp_rdata = 0;
        #1;
        chk("rst/out_valid", out_valid, 0);
        chk("rst/req_valid", dmem.req_valid, 0);
        chk("rst/in_ready", in_ready, 1);
        chk("rst/uart_we", uart_we, 0);
        chk("rst/MW_pc", MW_pc, 0);
        repeat (2) @(posedge clk);
        #1 rstd = 1;

        for (int i = 0; i < 6; i++) begin
            in_valid = 1; is_load = vecs[i].ld; is_store = vecs[i].st; is_load_unsigned = 0;
            mem_access_width = vecs[i].wd; alu_result = vecs[i].addr; w_data = 32'h5A5A_5A5A;
            w_enable = 1; rd_addr = vecs[i].rd; pc = 32'h1000 + 32'(i * 4);
            irreg_pc = 32'h2000 + 32'(i);
            #1;
            chk({vecs[i].nm, "/hc_access"}, hc_access, vecs[i].exp_hc);
            chk({vecs[i].nm, "/in_ready"}, in_ready, 1);
            step();
            clear_inputs();
            chk({vecs[i].nm, "/out_valid"}, out_valid, 1);
            chk({vecs[i].nm, "/MW_alu"}, MW_alu_result, vecs[i].addr);
            chk({vecs[i].nm, "/MW_misalign"}, MW_misalign, vecs[i].exp_mis);
            chk({vecs[i].nm, "/MW_wen"}, MW_w_enable, vecs[i].exp_wen);
            chk({vecs[i].nm, "/MW_r_data"}, MW_r_data, 0);
            chk({vecs[i].nm, "/MW_is_load"}, MW_is_load, vecs[i].ld);
            chk({vecs[i].nm, "/MW_pc"}, MW_pc, 32'h1000 + 32'(i * 4));
            chk({vecs[i].nm, "/MW_irreg_pc"}, MW_irreg_pc, 32'h2000 + 32'(i));
            chk({vecs[i].nm, "/MW_rd"}, MW_rd_addr, vecs[i].rd);
            chk({vecs[i].nm, "/no_req"}, dmem.req_valid, 0);
            chk({vecs[i].nm, "/uart_we"}, uart_we, 0);
            step();
            chk({vecs[i].nm, "/drained"}, out_valid, 0);
        end
        alu_result = 32'hFFFF_FF00;
        #1 chk("hc_no_valid", hc_access, 0);

        do_store("st_b", 32'h0000_0103, 2'b00, 32'h0000_00AB, 0, 4'b1000, 32'hAB00_0000);
        step();
        do_store("st_h", 32'h0000_0102, 2'b01, 32'h1234_BEEF, 2, 4'b1100, 32'hBEEF_0000);
        step();
        do_store("st_w", 32'h0000_0010, 2'b10, 32'hCAFE_F00D, 0, 4'b1111, 32'hCAFE_F00D);
        step();

        do_load("ld_hs", 32'h0000_0202, 2'b01, 1'b0, 32'h8001_0000, 3, 32'hFFFF_8001, 4'b1100);
        step();
        do_load("ld_hu", 32'h0000_0202, 2'b01, 1'b1, 32'h8001_0000, 3, 32'h0000_8001, 4'b1100);
        step();
        do_load("ld_bs", 32'h0000_0101, 2'b00, 1'b0, 32'h0000_8000, 0, 32'hFFFF_FF80, 4'b0010);
        step();
        do_load("ld_bu", 32'h0000_0103, 2'b00, 1'b1, 32'hFF00_0000, 1, 32'h0000_00FF, 4'b1000);
        step();

        in_valid = 1; is_store = 1; mem_access_width = 2'b00;
        alu_result = 32'hF6FF_F070; w_data = 32'h0000_0041;
        step();
        clear_inputs();
        chk("uart/data", uart, 8'h41);
        chk("uart/we", uart_we, 1);
        chk("uart/out_valid", out_valid, 1);
        chk("uart/no_req", dmem.req_valid, 0);
        step();
        chk("uart/we_off", uart_we, 0);
        chk("uart/hold", uart, 8'h41);
        chk("uart/no_req2", dmem.req_valid, 0);

        out_ready = 0;
        do_load("bp_ld", 32'h0000_0300, 2'b11, 1'b0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 4'b1111);
        in_valid = 1; is_load = 1; alu_result = 32'h0000_0500; mem_access_width = 2'b10;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("bp/out_valid", out_valid, 1);
            chk("bp/MW_r_data", MW_r_data, 32'hDEAD_BEEF);
            chk("bp/MW_alu", MW_alu_result, 32'h0000_0300);
            chk("bp/in_ready", in_ready, 0);
            chk("bp/no_req", dmem.req_valid, 0);
        end
        out_ready = 1;
        #1 chk("bp/in_ready_free", in_ready, 1);
        step();
        clear_inputs();
        chk("bp/drained", out_valid, 0);
        chk("bp/req_valid", dmem.req_valid, 1);
        chk("bp/req_addr", dmem.req_addr, 32'h0000_0500);

        #2 rstd = 0;
        #1;
        chk("rst2/out_valid", out_valid, 0);
        chk("rst2/req_valid", dmem.req_valid, 0);
        chk("rst2/MW_r_data", MW_r_data, 0);
        chk("rst2/MW_alu", MW_alu_result, 0);
        chk("rst2/MW_pc", MW_pc, 0);
        chk("rst2/MW_is_load", MW_is_load, 0);
        chk("rst2/uart", uart, 0);
        chk("rst2/in_ready", in_ready, 1);
        step();
        #1 rstd = 1;
        dmem.req_ready = 1;
        step();
        dmem.req_ready = 0;
        chk("rst2/idle_req", dmem.req_valid, 0);
        chk("rst2/no_complete", out_valid, 0);
        step();
        chk("rst2/still_idle", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
